apb_mem_ctrl: RTL and testbench

APB completer-side controller sitting directly downstream of apb_bridge. It consumes the bridge's outbound APB transfers and converts each into a single-cycle write or read strobe on the synchronous word memory interface. Adds programmable wait states, address-window decode with an error response, and registered read-data return.

---
 rtl/apb_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_apb_mem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_ctrl.sv
// APB completer that turns each transfer into one strobe on a synchronous
// word memory, with wait states, window decode and registered responses.
module apb_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_SIZE = DATA_WIDTH/8,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE = '0,
  parameter int MEM_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_SIZE-1:0]  pstrb,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [STRB_SIZE-1:0]  mem_be,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_MEM, S_RDLAT, S_RESP, S_ERR
  } state_t;

  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  state_t                state, nxt;
  logic [3:0]            cnt, cnt_n;
  logic                  cap_wr, cap_wr_n;
  logic [ADDR_WIDTH-1:0] cap_off, cap_off_n;
  logic [DATA_WIDTH-1:0] cap_wdata, cap_wdata_n;
  logic [STRB_SIZE-1:0]  cap_strb, cap_strb_n;

  logic                  pready_n, pslverr_n, mem_wr_n, mem_rd_n;
  logic [DATA_WIDTH-1:0] prdata_n, mem_data_in_n;
  logic [STRB_SIZE-1:0]  mem_be_n;
  logic [ADDR_WIDTH-1:0] mem_address_n;

  logic [ADDR_WIDTH-1:0] off;
  logic                  in_win, abort;

  assign off    = paddr - MEM_BASE;
  assign in_win = (paddr >= MEM_BASE) &&
                  (off < ADDR_WIDTH'(MEM_WORDS));
  assign abort  = !(psel && penable);

  always_comb begin
    nxt           = state;
    cnt_n         = cnt;
    cap_wr_n      = cap_wr;
    cap_off_n     = cap_off;
    cap_wdata_n   = cap_wdata;
    cap_strb_n    = cap_strb;
    pready_n      = 1'b0;
    pslverr_n     = 1'b0;
    prdata_n      = '0;
    mem_wr_n      = 1'b0;
    mem_rd_n      = 1'b0;
    mem_be_n      = '0;
    mem_address_n = '0;
    mem_data_in_n = '0;
    unique case (state)
      S_IDLE: begin
        if (psel && !penable) begin
          cap_wr_n    = pwrite;
          cap_off_n   = off;
          cap_wdata_n = pwdata;
          cap_strb_n  = pstrb;
          cnt_n       = '0;
          if (!in_win) begin
            nxt       = S_ERR;
            pready_n  = 1'b1;
            pslverr_n = 1'b1;
          end else if (WAIT_STATES == 0) begin
            nxt = S_MEM;
          end else begin
            nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (abort)                nxt = S_IDLE;
        else if (cnt == WS_LAST)  nxt = S_MEM;
        else if (cnt != 4'hF)     cnt_n = cnt + 4'd1;
      end
      S_MEM: begin
        if (abort) begin
          nxt = S_IDLE;
        end else if (cap_wr) begin
          nxt      = S_RESP;
          pready_n = 1'b1;
        end else begin
          nxt = S_RDLAT;
        end
      end
      S_RDLAT: begin
        if (abort) begin
          nxt = S_IDLE;
        end else begin
          nxt      = S_RESP;
          pready_n = 1'b1;
          prdata_n = mem_data_out;
        end
      end
      S_RESP:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // MEM is never re-entered from itself, so this fires once per transfer
    if (nxt == S_MEM) begin
      if (cap_wr_n) begin
        if (|cap_strb_n) begin
          mem_wr_n      = 1'b1;
          mem_be_n      = cap_strb_n;
          mem_address_n = cap_off_n;
          mem_data_in_n = cap_wdata_n;
        end
      end else begin
        mem_rd_n      = 1'b1;
        mem_be_n      = '1;
        mem_address_n = cap_off_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cap_wr      <= 1'b0;
      cap_off     <= '0;
      cap_wdata   <= '0;
      cap_strb    <= '0;
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      prdata      <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_be      <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      state       <= nxt;
      cnt         <= cnt_n;
      cap_wr      <= cap_wr_n;
      cap_off     <= cap_off_n;
      cap_wdata   <= cap_wdata_n;
      cap_strb    <= cap_strb_n;
      pready      <= pready_n;
      pslverr     <= pslverr_n;
      prdata      <= prdata_n;
      mem_wr      <= mem_wr_n;
      mem_rd      <= mem_rd_n;
      mem_be      <= mem_be_n;
      mem_address <= mem_address_n;
      mem_data_in <= mem_data_in_n;
    end
  end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Directed bench for apb_mem_ctrl: APB driver, word memory model,
// one task per scenario with inline expected-value checks.
module tb_apb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        mem_wr;
  logic        mem_rd;
  logic [3:0]  mem_be;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;

  int vec = 0;
  int miss = 0;
  int wr_pulses = 0;
  logic [31:0] mem [256];

  apb_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_be(mem_be),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // synchronous word memory: read data appears the cycle after mem_rd
  always @(posedge clk) begin
    if (mem_wr)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_address[7:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
    if (mem_rd) mem_data_out <= mem[mem_address[7:0]];
  end

  always @(negedge clk) if (mem_wr) wr_pulses++;

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // one APB transfer; observations are returned, checks live in the callers
  task automatic xfer(
    input  logic wr, input logic [31:0] a, input logic [31:0] d,
    input  logic [3:0] s,
    output int rdy_c, output logic [31:0] rd, output logic err,
    output int wr_c, output int rd_c, output int nstb,
    output logic [3:0] be, output logic [31:0] ma, output logic [31:0] md,
    output logic viol);
    rdy_c = -1; rd = 'x; err = 1'bx; wr_c = -1; rd_c = -1; nstb = 0;
    be = '0; ma = '0; md = '0; viol = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (mem_wr) begin
        wr_c = k; nstb++; be = mem_be; ma = mem_address; md = mem_data_in;
      end
      if (mem_rd) begin
        rd_c = k; nstb++; be = mem_be; ma = mem_address;
      end
      if (mem_wr && mem_rd) viol = 1'b1;
      if (!pready && (prdata !== '0 || pslverr !== 1'b0)) viol = 1'b1;
      if (pready) begin
        rdy_c = k; rd = prdata; err = pslverr;
        break;
      end
    end
  endtask

  int rc, wc, dc, ns;
  logic [31:0] rd, ma, md;
  logic [3:0] be;
  logic err, viol;

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    vec++;
    if ({pready, pslverr, prdata, mem_wr, mem_rd, mem_be, mem_address, mem_data_in} !== '0) begin
      miss++; $display("FAIL reset_outputs: got pready=%b mem_wr=%b mem_rd=%b prdata=%h, required all zero", pready, mem_wr, mem_rd, prdata);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write();
    xfer(1'b1, 32'hF0, 32'h000A3210, 4'hF, rc, rd, err, wc, dc, ns, be, ma, md, viol);
    vec++; if (wc !== 2) begin miss++; $display("FAIL write_strobe_cycle: got %0d required 2", wc); end
    vec++; if (ma !== 32'hF0) begin miss++; $display("FAIL write_addr: got %h required 000000f0", ma); end
    vec++; if (be !== 4'hF) begin miss++; $display("FAIL write_be: got %h required f", be); end
    vec++; if (md !== 32'h000A3210) begin miss++; $display("FAIL write_data: got %h required 000a3210", md); end
    vec++; if (rc !== 3) begin miss++; $display("FAIL write_pready_cycle: got %0d required 3", rc); end
    vec++; if ({err, rd} !== 33'h0) begin miss++; $display("FAIL write_resp: got err=%b prdata=%h required 0/0", err, rd); end
    vec++; if (ns !== 1 || viol !== 1'b0) begin miss++; $display("FAIL write_protocol: got strobes=%0d viol=%b required 1/0", ns, viol); end
    idle();
  endtask

  task automatic test_read();
    xfer(1'b0, 32'hF0, 32'h0, 4'h0, rc, rd, err, wc, dc, ns, be, ma, md, viol);
    vec++; if (dc !== 2) begin miss++; $display("FAIL read_strobe_cycle: got %0d required 2", dc); end
    vec++; if (be !== 4'hF || ma !== 32'hF0) begin miss++; $display("FAIL read_be_addr: got be=%h addr=%h required f/000000f0", be, ma); end
    vec++; if (rc !== 4) begin miss++; $display("FAIL read_pready_cycle: got %0d required 4", rc); end
    vec++; if (rd !== 32'h000A3210 || err !== 1'b0) begin miss++; $display("FAIL read_data: got %h err=%b required 000a3210/0", rd, err); end
    vec++; if (ns !== 1 || wc !== -1 || viol !== 1'b0) begin miss++; $display("FAIL read_protocol: got strobes=%0d wr_cycle=%0d viol=%b required 1/-1/0", ns, wc, viol); end
    idle();
  endtask

  task automatic test_error();
    xfer(1'b1, 32'h100, 32'hDEAD, 4'hF, rc, rd, err, wc, dc, ns, be, ma, md, viol);
    vec++; if (rc !== 1) begin miss++; $display("FAIL err_pready_cycle: got %0d required 1", rc); end
    vec++; if (err !== 1'b1 || rd !== '0) begin miss++; $display("FAIL err_resp: got err=%b prdata=%h required 1/0", err, rd); end
    vec++; if (ns !== 0) begin miss++; $display("FAIL err_no_strobe: got %0d strobes required 0", ns); end
    idle();
  endtask

  task automatic test_back_to_back();
    int start;
    int bad;
    start = wr_pulses;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 32'hB0 + i, 32'hC0D942F0 + i, 4'hF, rc, rd, err, wc, dc, ns, be, ma, md, viol);
      vec++;
      if (wc !== 2 || rc !== 3 || ns !== 1 || ma !== 32'hB0 + i || md !== 32'hC0D942F0 + i) begin
        miss++; bad++;
        $display("FAIL b2b_%0d: got wr_cycle=%0d pready_cycle=%0d addr=%h data=%h required 2/3/%h/%h", i, wc, rc, ma, md, 32'hB0 + i, 32'hC0D942F0 + i);
      end
    end
    idle();
    @(posedge clk); #1;
    vec++; if (wr_pulses - start !== 8) begin miss++; $display("FAIL b2b_pulse_count: got %0d required 8", wr_pulses - start); end
    xfer(1'b0, 32'hB5, 32'h0, 4'h0, rc, rd, err, wc, dc, ns, be, ma, md, viol);
    vec++; if (rd !== 32'hC0D942F5) begin miss++; $display("FAIL b2b_readback: got %h required c0d942f5", rd); end
    idle();
  endtask

  task automatic test_strobes();
    xfer(1'b1, 32'h10, 32'h11223344, 4'h5, rc, rd, err, wc, dc, ns, be, ma, md, viol);
    vec++; if (be !== 4'h5 || wc !== 2) begin miss++; $display("FAIL strb5_be: got be=%h wr_cycle=%0d required 5/2", be, wc); end
    idle();
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rc, rd, err, wc, dc, ns, be, ma, md, viol);
    vec++; if (rd !== 32'h00220044) begin miss++; $display("FAIL strb5_readback: got %h required 00220044", rd); end
    idle();
    xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rc, rd, err, wc, dc, ns, be, ma, md, viol);
    vec++; if (ns !== 0) begin miss++; $display("FAIL strb0_no_write: got %0d strobes required 0", ns); end
    vec++; if (rc !== 3 || err !== 1'b0) begin miss++; $display("FAIL strb0_resp: got pready_cycle=%0d err=%b required 3/0", rc, err); end
    idle();
  endtask

  task automatic check_quiet(input string name);
    int seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (pready || mem_wr || mem_rd) seen++;
    end
    vec++; if (seen !== 0) begin miss++; $display("FAIL %s_quiet: got %0d active cycles required 0", name, seen); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hF0;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1;
    vec++; if (mem_rd !== 1'b1) begin miss++; $display("FAIL rstmid_mem_rd: got %b required 1", mem_rd); end
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    vec++;
    if ({pready, pslverr, prdata, mem_wr, mem_rd, mem_be, mem_address, mem_data_in} !== '0) begin
      miss++; $display("FAIL rstmid_outputs: got pready=%b mem_rd=%b be=%h addr=%h required all zero", pready, mem_rd, mem_be, mem_address);
    end
    @(posedge clk); #1;
    vec++; if (pready !== 1'b0) begin miss++; $display("FAIL rstmid_no_pready: got %b required 0", pready); end
    psel = 1'b0; penable = 1'b0;
    #2 rst_n = 1'b1;
    check_quiet("rstmid");
    // a write caught mid-strobe must also drop asynchronously
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hF4; pwdata = 32'h55; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1;
    vec++; if (mem_wr !== 1'b1) begin miss++; $display("FAIL rstwr_mem_wr: got %b required 1", mem_wr); end
    #2 rst_n = 1'b0; #1;
    vec++; if ({mem_wr, mem_be, mem_address, mem_data_in} !== '0) begin miss++; $display("FAIL rstwr_async_clear: got mem_wr=%b addr=%h required 0", mem_wr, mem_address); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    #2 rst_n = 1'b1;
    xfer(1'b0, 32'hF0, 32'h0, 4'h0, rc, rd, err, wc, dc, ns, be, ma, md, viol);
    vec++; if (rc !== 4 || rd !== 32'h000A3210 || err !== 1'b0) begin miss++; $display("FAIL rstmid_recover: got pready_cycle=%0d prdata=%h required 4/000a3210", rc, rd); end
    idle();
  endtask

  task automatic test_abort();
    int start;
    start = wr_pulses;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hF8; pwdata = 32'h77; pstrb = 4'hF;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    check_quiet("abort");
    vec++; if (wr_pulses !== start) begin miss++; $display("FAIL abort_no_write: got %0d pulses required 0", wr_pulses - start); end
    penable = 1'b0;
    xfer(1'b0, 32'hF0, 32'h0, 4'h0, rc, rd, err, wc, dc, ns, be, ma, md, viol);
    vec++; if (rc !== 4 || rd !== 32'h000A3210) begin miss++; $display("FAIL abort_recover: got pready_cycle=%0d prdata=%h required 4/000a3210", rc, rd); end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_write();
    test_read();
    test_error();
    test_back_to_back();
    test_strobes();
    test_reset_mid();
    test_abort();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
